// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order commit buffer. Rename allocates one entry per instruction at the
//   tail; functional units 0-2 and the memory unit mark entries complete by
//   index; completed entries retire from the head strictly in program order,
//   at most one per cycle, releasing the old physical register.
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   alloc_*                     allocation request and entry fields
//   alloc_index                 index granted this cycle (current tail)
//   rob_full/rob_empty/rob_count occupancy status
//   complete_*_unit{0,1,2,mem}  completion valid/index/value per unit
//   retire_*                    registered fields of the entry retired last edge
module reorder_buffer #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned PREG_W = 6,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              alloc_enable,
   input  logic              alloc_has_rd,
   input  logic [4:0]        alloc_arch_rd,
   input  logic [PREG_W-1:0] alloc_phys_rd,
   input  logic [PREG_W-1:0] alloc_old_phys_rd,
   output logic [IDX_W-1:0]  alloc_index,
   output logic              rob_full,
   output logic              rob_empty,
   output logic [IDX_W:0]    rob_count,

   input  logic              complete_enable_unit0,
   input  logic [IDX_W-1:0]  complete_index_unit0,
   input  logic [DATA_W-1:0] complete_val_unit0,
   input  logic              complete_enable_unit1,
   input  logic [IDX_W-1:0]  complete_index_unit1,
   input  logic [DATA_W-1:0] complete_val_unit1,
   input  logic              complete_enable_unit2,
   input  logic [IDX_W-1:0]  complete_index_unit2,
   input  logic [DATA_W-1:0] complete_val_unit2,
   input  logic              complete_enable_unitmem,
   input  logic [IDX_W-1:0]  complete_index_unitmem,
   input  logic [DATA_W-1:0] complete_val_unitmem,

   output logic              retire_enable,
   output logic              retire_has_rd,
   output logic [4:0]        retire_arch_rd,
   output logic [PREG_W-1:0] retire_phys_rd,
   output logic [PREG_W-1:0] retire_old_phys_rd,
   output logic [DATA_W-1:0] retire_val,
   output logic [IDX_W-1:0]  retire_index
);

   localparam logic [IDX_W:0]   DepthCnt = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0]   CntOne   = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0] IdxOne   = IDX_W'(1);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  ready_q, ready_d;
   logic              has_rd_q      [DEPTH];
   logic [4:0]        arch_rd_q     [DEPTH];
   logic [PREG_W-1:0] phys_rd_q     [DEPTH];
   logic [PREG_W-1:0] old_phys_rd_q [DEPTH];
   logic [DATA_W-1:0] val_q         [DEPTH];

   logic [IDX_W-1:0]  head_q, tail_q;
   logic [IDX_W:0]    count_q, count_d;

   logic              do_alloc;
   logic              do_retire;

   assign alloc_index = tail_q;
   assign rob_count   = count_q;
   assign rob_full    = (count_q == DepthCnt);
   assign rob_empty   = (count_q == '0);

   // Full is judged on pre-retire occupancy: no allocation into a slot freed this edge.
   assign do_alloc  = alloc_enable & ~rob_full;
   // Uses registered ready only, so a completion to the head retires one edge later.
   assign do_retire = valid_q[head_q] & ready_q[head_q];

   always_comb begin
      valid_d = valid_q;
      ready_d = ready_q;
      if (complete_enable_unit0 && valid_q[complete_index_unit0]) begin
         ready_d[complete_index_unit0] = 1'b1;
      end
      if (complete_enable_unit1 && valid_q[complete_index_unit1]) begin
         ready_d[complete_index_unit1] = 1'b1;
      end
      if (complete_enable_unit2 && valid_q[complete_index_unit2]) begin
         ready_d[complete_index_unit2] = 1'b1;
      end
      if (complete_enable_unitmem && valid_q[complete_index_unitmem]) begin
         ready_d[complete_index_unitmem] = 1'b1;
      end
      if (do_retire) begin
         valid_d[head_q] = 1'b0;
         ready_d[head_q] = 1'b0;
      end
      // Tail is never the retiring head: that would need count == 0 or DEPTH.
      if (do_alloc) begin
         valid_d[tail_q] = 1'b1;
         ready_d[tail_q] = 1'b0;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({do_alloc, do_retire})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q            <= '0;
         ready_q            <= '0;
         head_q             <= '0;
         tail_q             <= '0;
         count_q            <= '0;
         retire_enable      <= 1'b0;
         retire_has_rd      <= 1'b0;
         retire_arch_rd     <= '0;
         retire_phys_rd     <= '0;
         retire_old_phys_rd <= '0;
         retire_val         <= '0;
         retire_index       <= '0;
      end else begin
         valid_q       <= valid_d;
         ready_q       <= ready_d;
         count_q       <= count_d;
         retire_enable <= do_retire;
         if (do_alloc) begin
            tail_q <= tail_q + IdxOne;
         end
         if (do_retire) begin
            head_q             <= head_q + IdxOne;
            retire_has_rd      <= has_rd_q[head_q];
            retire_arch_rd     <= arch_rd_q[head_q];
            retire_phys_rd     <= phys_rd_q[head_q];
            retire_old_phys_rd <= old_phys_rd_q[head_q];
            retire_val         <= val_q[head_q];
            retire_index       <= head_q;
         end
      end
   end

   // Payload storage needs no reset; valid/ready gate every use.
   // Writes go lowest priority first so unit0 wins on a shared index.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (complete_enable_unitmem && valid_q[complete_index_unitmem]) begin
            val_q[complete_index_unitmem] <= complete_val_unitmem;
         end
         if (complete_enable_unit2 && valid_q[complete_index_unit2]) begin
            val_q[complete_index_unit2] <= complete_val_unit2;
         end
         if (complete_enable_unit1 && valid_q[complete_index_unit1]) begin
            val_q[complete_index_unit1] <= complete_val_unit1;
         end
         if (complete_enable_unit0 && valid_q[complete_index_unit0]) begin
            val_q[complete_index_unit0] <= complete_val_unit0;
         end
         if (do_alloc) begin
            has_rd_q[tail_q]      <= alloc_has_rd;
            arch_rd_q[tail_q]     <= alloc_arch_rd;
            phys_rd_q[tail_q]     <= alloc_phys_rd;
            old_phys_rd_q[tail_q] <= alloc_old_phys_rd;
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_en, a_has;
   logic [4:0]  a_arch;
   logic [5:0]  a_phys, a_old;
   logic [5:0]  alloc_index;
   logic        rob_full, rob_empty;
   logic [6:0]  rob_count;
   logic        c_en  [4];
   logic [5:0]  c_idx [4];
   logic [31:0] c_val [4];
   logic        retire_enable, retire_has_rd;
   logic [4:0]  retire_arch_rd;
   logic [5:0]  retire_phys_rd, retire_old_phys_rd, retire_index;
   logic [31:0] retire_val;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk(clk), .reset(rst),
      .alloc_enable(a_en), .alloc_has_rd(a_has), .alloc_arch_rd(a_arch),
      .alloc_phys_rd(a_phys), .alloc_old_phys_rd(a_old), .alloc_index(alloc_index),
      .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count),
      .complete_enable_unit0(c_en[0]), .complete_index_unit0(c_idx[0]),
      .complete_val_unit0(c_val[0]),
      .complete_enable_unit1(c_en[1]), .complete_index_unit1(c_idx[1]),
      .complete_val_unit1(c_val[1]),
      .complete_enable_unit2(c_en[2]), .complete_index_unit2(c_idx[2]),
      .complete_val_unit2(c_val[2]),
      .complete_enable_unitmem(c_en[3]), .complete_index_unitmem(c_idx[3]),
      .complete_val_unitmem(c_val[3]),
      .retire_enable(retire_enable), .retire_has_rd(retire_has_rd),
      .retire_arch_rd(retire_arch_rd), .retire_phys_rd(retire_phys_rd),
      .retire_old_phys_rd(retire_old_phys_rd), .retire_val(retire_val),
      .retire_index(retire_index)
   );

   // Reference model: in-flight instructions in program order.
   typedef struct {
      logic [5:0]  idx;
      logic        has_rd;
      logic [4:0]  arch;
      logic [5:0]  phys;
      logic [5:0]  old;
      logic        rdy;
      logic [31:0] val;
   } ent_t;

   ent_t        q[$];
   int          m_tail = 0;
   bit          model_valid = 0;
   logic        e_ren, e_has;
   logic [4:0]  e_arch;
   logic [5:0]  e_phys, e_old, e_idx;
   logic [31:0] e_val;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      rst = 1'b0; a_en = 1'b0; a_has = 1'b0; a_arch = '0; a_phys = '0; a_old = '0;
      for (int k = 0; k < 4; k++) begin
         c_en[k] = 1'b0; c_idx[k] = '0; c_val[k] = '0;
      end
   endtask

   task automatic model_edge();
      ent_t h;
      bit   ret;
      bit   can_alloc;
      if (rst) begin
         q.delete();
         m_tail = 0;
         e_ren = 0; e_has = 0; e_arch = '0; e_phys = '0; e_old = '0; e_val = '0; e_idx = '0;
         model_valid = 1;
         return;
      end
      can_alloc = (q.size() < 64);
      ret = (q.size() > 0) && q[0].rdy;
      if (ret) h = q[0];
      // Lowest priority first so unit0 ends up owning the value.
      for (int k = 3; k >= 0; k--) begin
         if (c_en[k]) begin
            foreach (q[i]) begin
               if (q[i].idx == c_idx[k]) begin
                  q[i].rdy = 1'b1;
                  q[i].val = c_val[k];
               end
            end
         end
      end
      e_ren = ret;
      if (ret) begin
         void'(q.pop_front());
         e_has = h.has_rd; e_arch = h.arch; e_phys = h.phys; e_old = h.old;
         e_val = h.val; e_idx = h.idx;
      end
      if (a_en && can_alloc) begin
         q.push_back('{idx: 6'(m_tail), has_rd: a_has, arch: a_arch, phys: a_phys,
                       old: a_old, rdy: 1'b0, val: 32'h0});
         m_tail = (m_tail + 1) % 64;
      end
   endtask

   // Called one time unit after a rising edge with inputs already driven.
   task automatic step();
      if (model_valid) begin
         check_eq("alloc_index", alloc_index, 64'(m_tail));
         check_eq("rob_count", rob_count, 64'(q.size()));
         check_eq("rob_full", rob_full, 64'(q.size() == 64));
         check_eq("rob_empty", rob_empty, 64'(q.size() == 0));
      end
      @(posedge clk);
      model_edge();
      #1;
      if (model_valid) begin
         check_eq("retire_enable", retire_enable, 64'(e_ren));
         check_eq("retire_has_rd", retire_has_rd, 64'(e_has));
         check_eq("retire_arch_rd", retire_arch_rd, 64'(e_arch));
         check_eq("retire_phys_rd", retire_phys_rd, 64'(e_phys));
         check_eq("retire_old_phys_rd", retire_old_phys_rd, 64'(e_old));
         check_eq("retire_val", retire_val, 64'(e_val));
         check_eq("retire_index", retire_index, 64'(e_idx));
      end
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         idle_inputs();
         rst = 1'b1;
         step();
      end
      idle_inputs();
   endtask

   task automatic do_alloc(input logic [4:0] arch, input logic [5:0] phys, input logic [5:0] old);
      idle_inputs();
      a_en = 1'b1; a_has = 1'b1; a_arch = arch; a_phys = phys; a_old = old;
      step();
      idle_inputs();
   endtask

   task automatic do_complete(input int unit, input logic [5:0] idx, input logic [31:0] val);
      idle_inputs();
      c_en[unit] = 1'b1; c_idx[unit] = idx; c_val[unit] = val;
      step();
      idle_inputs();
   endtask

   function automatic logic [5:0] pick_idx();
      if (q.size() == 0 || $urandom_range(7) == 0) return 6'($urandom_range(63));
      if ($urandom_range(3) == 0) return q[0].idx;
      return q[$urandom_range(q.size() - 1)].idx;
   endfunction

   function automatic int oldest_not_ready();
      foreach (q[i]) if (!q[i].rdy) return i;
      return -1;
   endfunction

   initial begin
      int pct [6] = '{60, 95, 20, 70, 98, 10};
      int j;
      idle_inputs();
      @(posedge clk);
      #1;

      // Reset and empty state
      do_reset(2);
      step();
      check_eq("empty_after_reset", rob_empty, 64'd1);

      // Single instruction
      do_alloc(5'd3, 6'd10, 6'd3);
      do_complete(1, 6'd0, 32'hDEADBEEF);
      step();
      check_eq("single_retire_val", retire_val, 64'hDEADBEEF);
      step();

      // Out-of-order completion
      do_reset(1);
      do_alloc(5'd1, 6'd20, 6'd1);
      do_alloc(5'd2, 6'd21, 6'd2);
      do_alloc(5'd4, 6'd22, 6'd4);
      do_complete(0, 6'd2, 32'hCAFEBABE);
      do_complete(2, 6'd1, 32'h11);
      do_complete(3, 6'd0, 32'h22);
      for (int i = 0; i < 4; i++) step();

      // Full and stall, then retire frees slot 0
      do_reset(1);
      for (int i = 0; i < 65; i++) do_alloc(5'(i), 6'(i), 6'(63 - i));
      check_eq("full_flag", rob_full, 64'd1);
      do_alloc(5'd31, 6'd63, 6'd63);
      do_complete(0, 6'd0, 32'h1234_5678);
      step();
      do_alloc(5'd7, 6'd7, 6'd7);

      // Wrap with simultaneous allocate and retire at steady occupancy
      do_reset(1);
      for (int i = 0; i < 4; i++) do_alloc(5'(i), 6'(i), 6'(i));
      for (int i = 0; i < 72; i++) begin
         idle_inputs();
         a_en = 1'b1; a_has = 1'($urandom); a_arch = 5'($urandom);
         a_phys = 6'($urandom); a_old = 6'($urandom);
         j = oldest_not_ready();
         if (j >= 0) begin
            c_en[0] = 1'b1; c_idx[0] = q[j].idx; c_val[0] = $urandom;
         end
         step();
      end

      // Randomized traffic with colliding completions and phases of fill/drain
      do_reset(1);
      for (int n = 0; n < 3000; n++) begin
         idle_inputs();
         a_en = ($urandom_range(99) < pct[n / 500]);
         a_has = 1'($urandom); a_arch = 5'($urandom);
         a_phys = 6'($urandom); a_old = 6'($urandom);
         for (int k = 0; k < 4; k++) begin
            c_en[k] = ($urandom_range(99) < 35);
            c_idx[k] = pick_idx();
            c_val[k] = $urandom;
         end
         step();
      end

      // Reset mid-flight
      do_reset(1);
      for (int i = 0; i < 10; i++) do_alloc(5'(i), 6'(i + 30), 6'(i));
      do_complete(0, 6'd1, 32'hA1);
      do_complete(1, 6'd3, 32'hA3);
      do_complete(2, 6'd5, 32'hA5);
      do_complete(3, 6'd7, 32'hA7);
      idle_inputs();
      rst = 1'b1; a_en = 1'b1; c_en[0] = 1'b1; c_idx[0] = 6'd0; c_val[0] = 32'hBAD;
      step();
      check_eq("count_after_reset", rob_count, 64'd0);
      do_complete(1, 6'd2, 32'hBEEF);
      do_alloc(5'd9, 6'd9, 6'd9);
      do_alloc(5'd8, 6'd8, 6'd8);
      do_alloc(5'd6, 6'd6, 6'd6);
      for (int i = 0; i < 3; i++) step();
      check_eq("late_complete_ignored", retire_enable, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
